// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the hardware performance counter bank: CSR numbers, counter
// indices and small decode helpers.
package hpm_counter_bank_pkg;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT31    = 12'h33F,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER31  = 12'hB1F,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER31H = 12'hB9F
    } csr_num_e;

    localparam int unsigned HPM_MAX_CNTRS = 29;
    localparam int unsigned HPM_IDX_CY    = 0;
    localparam int unsigned HPM_IDX_IR    = 2;

    // Owned CSRs sit in three aligned 32-entry blocks; addr[4:0] is the counter index.
    localparam logic [6:0] HPM_BLK_EVT = 7'h19;  // 0x320..0x33F
    localparam logic [6:0] HPM_BLK_LO  = 7'h58;  // 0xB00..0xB1F
    localparam logic [6:0] HPM_BLK_HI  = 7'h5C;  // 0xB80..0xB9F

    // Writable bits of mcountinhibit: CY, IR and one bit per implemented mhpmcounter.
    function automatic logic [31:0] hpm_inhibit_mask(input int unsigned n);
        logic [31:0] m;
        m = 32'h5;
        for (int unsigned b = 3; b < 32; b++) begin
            if (b <= n + 2) m[b] = 1'b1;
        end
        return m;
    endfunction

    // Index 1 (time) and mhpmevent1/2 are not owned by this block.
    function automatic logic hpm_csr_hit(input logic [11:0] a);
        logic hit;
        hit = 1'b0;
        case (a[11:5])
            HPM_BLK_EVT:             hit = (a[4:0] == 5'd0) || (a[4:0] >= 5'd3);
            HPM_BLK_LO, HPM_BLK_HI:  hit = (a[4:0] != 5'd1);
            default:                 hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// Single wrapping counter with split 32-bit low/high write ports and a one-cycle
// overflow pulse. A write in the same cycle as an increment wins and drops the increment.
module hpm_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             we_lo_i,
    input  logic             we_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [WIDTH-1:0] value_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] wr_lo_val, wr_hi_val;
    logic             ovf_q, ovf_d;

    if (WIDTH > 32) begin : g_wide
        assign wr_lo_val = {value_q[WIDTH-1:32], wdata_i};
        assign wr_hi_val = {wdata_i[WIDTH-33:0], value_q[31:0]};
    end else begin : g_narrow
        // No high half exists: high-half writes leave the value untouched.
        assign wr_lo_val = wdata_i[WIDTH-1:0];
        assign wr_hi_val = value_q;
    end

    // Next value: write beats increment; only a real wrap raises overflow.
    always_comb begin
        value_d = value_q;
        ovf_d   = 1'b0;
        if (we_lo_i) begin
            value_d = wr_lo_val;
        end else if (we_hi_i) begin
            value_d = wr_hi_val;
        end else if (inc_i) begin
            value_d = value_q + WIDTH'(1);
            ovf_d   = &value_q;
        end
    end

    // Counter and overflow pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value_o = value_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine-mode performance counter bank: mcycle, minstret and NUM_CNTRS programmable
// mhpmcounters with event masks and mcountinhibit, plus CSR decode and read mux.
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int unsigned NUM_CNTRS  = 8,
    parameter int unsigned CNTR_WIDTH = 40,
    parameter int unsigned NUM_EVENTS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [11:0]           csr_addr_i,
    input  logic                  csr_we_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    input  logic                  instr_ret_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  debug_mode_i,
    output logic [31:0]           ovf_o
);

    localparam int unsigned LastCntr = NUM_CNTRS + 2;
    localparam logic [31:0] InhMask  = hpm_inhibit_mask(NUM_CNTRS);

    logic [6:0]            blk;
    logic [4:0]            idx;
    logic                  inh_wr;
    logic                  count_en;
    logic [31:0]           inh_q, inh_d;
    logic [63:0]           cnt_val  [32];
    logic [NUM_EVENTS-1:0] evt_mask [32];
    logic [31:0]           ovf_vec;

    assign blk      = csr_addr_i[11:5];
    assign idx      = csr_addr_i[4:0];
    assign count_en = !debug_mode_i;
    assign inh_wr   = csr_we_i && (blk == HPM_BLK_EVT) && (idx == 5'd0);

    // New inhibit value already gates this cycle's increments.
    assign inh_d = inh_wr ? (csr_wdata_i & InhMask) : inh_q;

    // mcountinhibit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inh_q <= '0;
        else         inh_q <= inh_d;
    end

    for (genvar i = 0; i < 32; i++) begin : g_cnt
        localparam logic [4:0] Idx = 5'(i);
        logic we_lo, we_hi;
        assign we_lo = csr_we_i && (blk == HPM_BLK_LO) && (idx == Idx);
        assign we_hi = csr_we_i && (blk == HPM_BLK_HI) && (idx == Idx);

        if (i == HPM_IDX_CY || i == HPM_IDX_IR) begin : g_fixed
            logic [63:0] val;
            logic        inc;
            assign inc = count_en && !inh_d[i] && ((i == HPM_IDX_CY) || instr_ret_i);
            hpm_counter #(.WIDTH(64)) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .inc_i   (inc),
                .we_lo_i (we_lo),
                .we_hi_i (we_hi),
                .wdata_i (csr_wdata_i),
                .value_o (val),
                .ovf_o   (ovf_vec[i])
            );
            assign cnt_val[i]  = val;
            assign evt_mask[i] = '0;
        end else if (i >= 3 && i <= LastCntr) begin : g_hpm
            logic [CNTR_WIDTH-1:0] val;
            logic [NUM_EVENTS-1:0] evt_q;
            logic                  evt_we, inc;
            assign evt_we = csr_we_i && (blk == HPM_BLK_EVT) && (idx == Idx);
            // Event selection mask; a new mask takes effect from the next cycle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)     evt_q <= '0;
                else if (evt_we) evt_q <= csr_wdata_i[NUM_EVENTS-1:0];
            end
            assign inc = count_en && !inh_d[i] && |(event_i & evt_q);
            hpm_counter #(.WIDTH(CNTR_WIDTH)) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .inc_i   (inc),
                .we_lo_i (we_lo),
                .we_hi_i (we_hi),
                .wdata_i (csr_wdata_i),
                .value_o (val),
                .ovf_o   (ovf_vec[i])
            );
            assign cnt_val[i]  = 64'(val);
            assign evt_mask[i] = evt_q;
        end else begin : g_none
            assign cnt_val[i]  = '0;
            assign evt_mask[i] = '0;
            assign ovf_vec[i]  = 1'b0;
        end
    end

    // Combinational read mux; unimplemented entries are tied to zero above.
    always_comb begin
        csr_rdata_o = '0;
        case (blk)
            HPM_BLK_EVT: csr_rdata_o = (idx == 5'd0) ? inh_q : 32'(evt_mask[idx]);
            HPM_BLK_LO:  csr_rdata_o = cnt_val[idx][31:0];
            HPM_BLK_HI:  csr_rdata_o = cnt_val[idx][63:32];
            default:     csr_rdata_o = '0;
        endcase
    end

    assign csr_hit_o = hpm_csr_hit(csr_addr_i);
    assign ovf_o     = ovf_vec;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised and directed bench for hpm_counter_bank against a behavioural model.
module tb_hpm_counter_bank;

    localparam int unsigned NC = 8;
    localparam int unsigned CW = 40;
    localparam int unsigned NE = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [11:0]   csr_addr_i = '0;
    logic          csr_we_i = 1'b0;
    logic [31:0]   csr_wdata_i = '0;
    logic [31:0]   csr_rdata_o;
    logic          csr_hit_o;
    logic          instr_ret_i = 1'b0;
    logic [NE-1:0] event_i = '0;
    logic          debug_mode_i = 1'b1;
    logic [31:0]   ovf_o;

    always #5 clk_i = ~clk_i;

    hpm_counter_bank #(
        .NUM_CNTRS  (NC),
        .CNTR_WIDTH (CW),
        .NUM_EVENTS (NE)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .csr_addr_i   (csr_addr_i),
        .csr_we_i     (csr_we_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_hit_o    (csr_hit_o),
        .instr_ret_i  (instr_ret_i),
        .event_i      (event_i),
        .debug_mode_i (debug_mode_i),
        .ovf_o        (ovf_o)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference state: counter values, event masks, inhibit, pending overflow pulses.
    longint unsigned m_cnt [32];
    logic [31:0]     m_evt [32];
    logic [31:0]     m_inh;
    logic [31:0]     m_ovf;
    logic [31:0]     rd_seen;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit impl(input int i);
        return (i == 0) || (i == 2) || (i >= 3 && i <= int'(NC) + 2);
    endfunction

    function automatic longint unsigned wmask(input int i);
        if (i < 3) return 64'hFFFF_FFFF_FFFF_FFFF;
        return (64'd1 << CW) - 64'd1;
    endfunction

    function automatic logic [31:0] inh_mask();
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 32; i++) if (impl(i)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic mdl_hit(input logic [11:0] a);
        if (a == 12'h320) return 1'b1;
        if (a >= 12'h323 && a <= 12'h33F) return 1'b1;
        if (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) return 1'b1;
        if (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [11:0] a);
        longint unsigned v;
        if (a == 12'h320) return m_inh;
        if (a >= 12'h323 && a <= 12'h33F) return m_evt[int'(a - 12'h320)];
        if (a >= 12'hB00 && a <= 12'hB1F) begin
            v = m_cnt[int'(a - 12'hB00)];
            return v[31:0];
        end
        if (a >= 12'hB80 && a <= 12'hB9F) begin
            v = m_cnt[int'(a - 12'hB80)];
            return v[63:32];
        end
        return 32'h0;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_evt[i] = '0;
        end
        m_inh = '0;
        m_ovf = '0;
    endtask

    // One clock of the architectural rules: writes replace, otherwise count mod 2^width.
    task automatic mdl_step(input logic [11:0] a, input logic we, input logic [31:0] wd,
                            input logic ret, input logic [NE-1:0] ev, input logic dbg);
        logic [31:0] inh;
        logic        counts;
        int          e;
        inh = m_inh;
        if (we && a == 12'h320) inh = wd & inh_mask();
        m_ovf = '0;
        for (int i = 0; i < 32; i++) begin
            if (!impl(i)) continue;
            if (we && a == 12'hB00 + 12'(i)) begin
                m_cnt[i] = ((m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | 64'(wd)) & wmask(i);
            end else if (we && a == 12'hB80 + 12'(i)) begin
                m_cnt[i] = ((m_cnt[i] & 64'hFFFF_FFFF) | (64'(wd) << 32)) & wmask(i);
            end else if (!dbg && !inh[i]) begin
                if (i == 0)      counts = 1'b1;
                else if (i == 2) counts = ret;
                else             counts = |(32'(ev) & m_evt[i]);
                if (counts) begin
                    if (m_cnt[i] == wmask(i)) begin
                        m_cnt[i] = 0;
                        m_ovf[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        if (we && a >= 12'h323 && a <= 12'h33F) begin
            e = int'(a - 12'h320);
            if (impl(e)) m_evt[e] = wd & ((32'd1 << NE) - 32'd1);
        end
        m_inh = inh;
    endtask

    // Called at posedge+1: drive, check read mux at negedge, clock, check overflow.
    task automatic cycle(input logic [11:0] a, input logic we, input logic [31:0] wd,
                         input logic ret, input logic [NE-1:0] ev, input logic dbg);
        csr_addr_i   = a;
        csr_we_i     = we;
        csr_wdata_i  = wd;
        instr_ret_i  = ret;
        event_i      = ev;
        debug_mode_i = dbg;
        @(negedge clk_i);
        rd_seen = csr_rdata_o;
        chk($sformatf("rdata@%h", a), csr_rdata_o, mdl_read(a));
        chk($sformatf("hit@%h", a), csr_hit_o, mdl_hit(a));
        @(posedge clk_i);
        mdl_step(a, we, wd, ret, ev, dbg);
        #1;
        chk("ovf", ovf_o, m_ovf);
    endtask

    // Frozen read: debug mode stops all counting for this cycle.
    task automatic peek(input logic [11:0] a, input string tag, input logic [31:0] exp);
        cycle(a, 1'b0, 32'h0, 1'b0, '0, 1'b1);
        chk(tag, rd_seen, exp);
    endtask

    logic [11:0] pool [22] = '{12'h320, 12'h323, 12'h324, 12'h32A, 12'h33F, 12'hB00,
                               12'hB02, 12'hB03, 12'hB04, 12'hB0A, 12'hB0B, 12'hB1F,
                               12'hB80, 12'hB82, 12'hB83, 12'hB84, 12'hB8A, 12'hB9F,
                               12'hB01, 12'h321, 12'h300, 12'hC00};

    initial begin
        longint unsigned snap_cy, snap_ir;
        logic [11:0] a;
        logic        we;
        logic [31:0] wd;
        mdl_reset();

        // Reset state, sampled while reset is held.
        #12;
        chk("rst_ovf", ovf_o, 32'h0);
        csr_addr_i = 12'hB00; #1; chk("rst_mcycle", csr_rdata_o, 32'h0);
        csr_addr_i = 12'h320; #1; chk("rst_inh", csr_rdata_o, 32'h0);
        csr_addr_i = 12'hB01; #1; chk("rst_hit_time", csr_hit_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Free run 10 cycles, 4 retirements.
        for (int i = 0; i < 10; i++) cycle(12'h0, 1'b0, 32'h0, i < 4, '0, 1'b0);
        peek(12'hB00, "run_mcycle", 32'd10);
        peek(12'hB02, "run_minstret", 32'd4);
        peek(12'hB03, "run_hpm3", 32'd0);
        peek(12'hB80, "run_mcycleh", 32'd0);

        // Event mask 0x5 on counter 3.
        cycle(12'h323, 1'b1, 32'h5, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(12'h0, 1'b0, 32'h0, 1'b0, 16'h0001, 1'b0);
        for (int i = 0; i < 2; i++) cycle(12'h0, 1'b0, 32'h0, 1'b0, 16'h0004, 1'b0);
        cycle(12'h0, 1'b0, 32'h0, 1'b0, 16'h0005, 1'b0);
        for (int i = 0; i < 2; i++) cycle(12'h0, 1'b0, 32'h0, 1'b0, 16'h0002, 1'b0);
        peek(12'hB03, "evt_hpm3", 32'd6);
        peek(12'h323, "evt_mask3", 32'h5);

        // mcycle carry into high half without overflow.
        cycle(12'hB00, 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        cycle(12'hB80, 1'b1, 32'h0, 1'b0, '0, 1'b0);
        cycle(12'h0, 1'b0, 32'h0, 1'b0, '0, 1'b0);
        chk("carry_ovf0", ovf_o[0], 1'b0);
        peek(12'hB00, "carry_lo", 32'h0);
        peek(12'hB80, "carry_hi", 32'h1);

        // 40-bit mhpmcounter4 wrap.
        cycle(12'h324, 1'b1, 32'h1, 1'b0, '0, 1'b0);
        cycle(12'hB84, 1'b1, 32'hFF, 1'b0, '0, 1'b0);
        cycle(12'hB04, 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        cycle(12'h0, 1'b0, 32'h0, 1'b0, 16'h0001, 1'b0);
        chk("wrap_ovf4_hi", ovf_o[4], 1'b1);
        peek(12'hB04, "wrap_lo", 32'h0);
        chk("wrap_ovf4_lo", ovf_o[4], 1'b0);
        peek(12'hB84, "wrap_hi", 32'h0);

        // Inhibit then debug freeze, then resume.
        cycle(12'h320, 1'b1, 32'h5, 1'b1, '0, 1'b0);
        snap_cy = m_cnt[0];
        snap_ir = m_cnt[2];
        for (int i = 0; i < 8; i++) cycle(12'h0, 1'b0, 32'h0, 1'b1, '0, 1'b0);
        peek(12'hB00, "inh_cy", 32'(snap_cy));
        peek(12'hB02, "inh_ir", 32'(snap_ir));
        cycle(12'h320, 1'b1, 32'h0, 1'b0, '0, 1'b0);
        snap_cy = m_cnt[0];
        snap_ir = m_cnt[2];
        for (int i = 0; i < 8; i++) cycle(12'h0, 1'b0, 32'h0, 1'b1, '0, 1'b1);
        peek(12'hB00, "dbg_cy", 32'(snap_cy));
        for (int i = 0; i < 3; i++) cycle(12'h0, 1'b0, 32'h0, 1'b1, '0, 1'b0);
        peek(12'hB00, "resume_cy", 32'(snap_cy + 3));
        peek(12'hB02, "resume_ir", 32'(snap_ir + 3));

        // Write beats same-cycle event; unimplemented counter ignores writes.
        cycle(12'hB03, 1'b1, 32'h100, 1'b0, 16'h0001, 1'b0);
        peek(12'hB03, "wr_wins", 32'h100);
        cycle(12'hB14, 1'b1, 32'h1234, 1'b0, '0, 1'b0);
        peek(12'hB14, "unimpl_cnt", 32'h0);
        cycle(12'h334, 1'b1, 32'hFFFF, 1'b0, '0, 1'b0);
        peek(12'h334, "unimpl_evt", 32'h0);
        cycle(12'h325, 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        peek(12'h325, "evt_warl", 32'h0000_FFFF);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            a  = pool[$urandom_range(0, 21)];
            we = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                if (a[7]) wd = 32'hFF;
                else      wd = 32'hFFFF_FFFF - $urandom_range(0, 3);
            end
            cycle(a, we, wd, 1'($urandom), NE'($urandom), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset with an overflow pulse outstanding.
        cycle(12'h320, 1'b1, 32'h0, 1'b0, '0, 1'b0);
        cycle(12'h325, 1'b1, 32'h1, 1'b0, '0, 1'b0);
        cycle(12'hB85, 1'b1, 32'hFF, 1'b0, '0, 1'b0);
        cycle(12'hB05, 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
        cycle(12'hB00, 1'b0, 32'h0, 1'b0, 16'h0001, 1'b0);
        chk("pre_rst_ovf5", ovf_o[5], 1'b1);
        debug_mode_i = 1'b1;
        csr_we_i     = 1'b0;
        event_i      = '0;
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_ovf", ovf_o, 32'h0);
        chk("async_rst_cnt", csr_rdata_o, 32'h0);
        mdl_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_ovf", ovf_o, 32'h0);
        peek(12'hB05, "post_rst_hpm5", 32'h0);
        peek(12'h325, "post_rst_evt5", 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
